// File: rtl/fq_ps2_pkg.sv
// Shared definitions for the PS/2 button receiver.
// Contents: scan-code constants, frame FSM state encoding, button index constants and the
// {extended, byte} -> button lookup used by the decoder.
package fq_ps2_pkg;

   // Prefix bytes
   localparam logic [7:0] SC_BREAK = 8'hF0;
   localparam logic [7:0] SC_EXT   = 8'hE0;

   // team1 keys (W/S/A/D), non-extended
   localparam logic [7:0] SC_T1_VU = 8'h1D;
   localparam logic [7:0] SC_T1_VD = 8'h1B;
   localparam logic [7:0] SC_T1_HL = 8'h1C;
   localparam logic [7:0] SC_T1_HR = 8'h23;

   // team2 keys (arrow keys), E0-prefixed
   localparam logic [7:0] SC_T2_VU = 8'h75;
   localparam logic [7:0] SC_T2_VD = 8'h72;
   localparam logic [7:0] SC_T2_HL = 8'h6B;
   localparam logic [7:0] SC_T2_HR = 8'h74;

   // Button indices into the held-state vector
   localparam logic [2:0] BTN_T1_VU = 3'd0;
   localparam logic [2:0] BTN_T1_VD = 3'd1;
   localparam logic [2:0] BTN_T1_HL = 3'd2;
   localparam logic [2:0] BTN_T1_HR = 3'd3;
   localparam logic [2:0] BTN_T2_VU = 3'd4;
   localparam logic [2:0] BTN_T2_VD = 3'd5;
   localparam logic [2:0] BTN_T2_HL = 3'd6;
   localparam logic [2:0] BTN_T2_HR = 3'd7;

   typedef enum logic [1:0] {
      StIdle,
      StData,
      StParity,
      StStop
   } frame_state_e;

   typedef struct packed {
      logic       hit;
      logic [2:0] idx;
   } key_hit_t;

   // Map an {extended, byte} pair to a button. Anything not listed is unmapped.
   function automatic key_hit_t key_lookup(input logic ext, input logic [7:0] sc);
      key_hit_t r;
      r.hit = 1'b1;
      r.idx = 3'd0;
      case ({ext, sc})
         {1'b0, SC_T1_VU}: r.idx = BTN_T1_VU;
         {1'b0, SC_T1_VD}: r.idx = BTN_T1_VD;
         {1'b0, SC_T1_HL}: r.idx = BTN_T1_HL;
         {1'b0, SC_T1_HR}: r.idx = BTN_T1_HR;
         {1'b1, SC_T2_VU}: r.idx = BTN_T2_VU;
         {1'b1, SC_T2_VD}: r.idx = BTN_T2_VD;
         {1'b1, SC_T2_HL}: r.idx = BTN_T2_HL;
         {1'b1, SC_T2_HR}: r.idx = BTN_T2_HR;
         default:          r.hit = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver (keyboard-to-host direction).
// Synchronises both pins, debounces ps2_clk, and deserialises 11-bit frames
// (start, 8 data LSB first, odd parity, stop) with a mid-frame inactivity timeout.
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   ps2_clk         raw PS/2 clock pin (asynchronous)
//   ps2_data        raw PS/2 data pin (asynchronous)
//   code            last good byte, held until the next good byte
//   code_valid      one-cycle pulse with each good byte
//   frame_error     one-cycle pulse on parity, stop or timeout failure
module ps2_frame_rx
   import fq_ps2_pkg::*;
#(
   parameter int unsigned FILTER_LEN     = 8,
   parameter int unsigned TIMEOUT_CYCLES = 50000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] code,
   output logic       code_valid,
   output logic       frame_error
);

   localparam int unsigned FW = $clog2(FILTER_LEN) + 1;
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

   logic clk_meta_q, clk_sync_q, data_meta_q, data_sync_q;
   logic          filt_q, filt_d;
   logic [FW-1:0] fcnt_q, fcnt_d;
   logic          fall;

   frame_state_e  state_q, state_d;
   logic [2:0]    bit_cnt_q, bit_cnt_d;
   logic [7:0]    shift_q, shift_d;
   logic          parity_q, parity_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic [7:0]    code_q, code_d;
   logic          valid_q, valid_d;
   logic          err_q, err_d;

   // Two-flop synchronisers; idle bus level is high.
   always_ff @(posedge clk) begin
      if (rst) begin
         clk_meta_q  <= 1'b1;
         clk_sync_q  <= 1'b1;
         data_meta_q <= 1'b1;
         data_sync_q <= 1'b1;
      end else begin
         clk_meta_q  <= ps2_clk;
         clk_sync_q  <= clk_meta_q;
         data_meta_q <= ps2_data;
         data_sync_q <= data_meta_q;
      end
   end

   // Filtered clock only follows the synchronised pin after FILTER_LEN consecutive cycles
   // at the new level; shorter excursions reset the count.
   always_comb begin
      filt_d = filt_q;
      fcnt_d = '0;
      fall   = 1'b0;
      if (clk_sync_q != filt_q) begin
         if (fcnt_q == FW'(FILTER_LEN - 1)) begin
            filt_d = clk_sync_q;
            fall   = filt_q;
         end else begin
            fcnt_d = fcnt_q + FW'(1);
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      parity_d  = parity_q;
      code_d    = code_q;
      valid_d   = 1'b0;
      err_d     = 1'b0;

      if (fall || state_q == StIdle) begin
         tmo_d = '0;
      end else begin
         tmo_d = tmo_q + TW'(1);
      end

      case (state_q)
         StIdle: begin
            if (fall && !data_sync_q) begin
               state_d   = StData;
               bit_cnt_d = 3'd0;
            end
         end
         StData: begin
            if (fall) begin
               shift_d   = {data_sync_q, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  state_d = StParity;
               end
            end
         end
         StParity: begin
            if (fall) begin
               parity_d = data_sync_q;
               state_d  = StStop;
            end
         end
         StStop: begin
            if (fall) begin
               state_d = StIdle;
               if ((^{shift_q, parity_q}) && data_sync_q) begin
                  code_d  = shift_q;
                  valid_d = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         default: state_d = StIdle;
      endcase

      // Abort a stalled frame; an edge on this same cycle restarts the count instead.
      if (state_q != StIdle && !fall && tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
         state_d = StIdle;
         err_d   = 1'b1;
         tmo_d   = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         filt_q    <= 1'b1;
         fcnt_q    <= '0;
         state_q   <= StIdle;
         bit_cnt_q <= 3'd0;
         shift_q   <= 8'h00;
         parity_q  <= 1'b0;
         tmo_q     <= '0;
         code_q    <= 8'h00;
         valid_q   <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         filt_q    <= filt_d;
         fcnt_q    <= fcnt_d;
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         parity_q  <= parity_d;
         tmo_q     <= tmo_d;
         code_q    <= code_d;
         valid_q   <= valid_d;
         err_q     <= err_d;
      end
   end

   assign code        = code_q;
   assign code_valid  = valid_q;
   assign frame_error = err_q;

endmodule

// File: rtl/ps2_button_receiver.sv
// PS/2 keyboard to eight held-level button signals for game_controller.
// Decodes F0 (break) and E0 (extended) prefixes and maps W/S/A/D to team1 and the
// arrow keys to team2.
// Ports:
//   clk, rst                      system clock (50 MHz), synchronous active-high reset
//   ps2_clk, ps2_data             raw PS/2 pins (asynchronous)
//   team1_*_button, team2_*_button  held state per key (ACTIVE_LEVEL while held)
//   code, code_valid, frame_error   receiver status from the frame layer
module ps2_button_receiver
   import fq_ps2_pkg::*;
#(
   parameter int unsigned FILTER_LEN     = 8,
   parameter int unsigned TIMEOUT_CYCLES = 50000,
   parameter logic        ACTIVE_LEVEL   = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic       team1_vu_button,
   output logic       team1_vd_button,
   output logic       team1_hl_button,
   output logic       team1_hr_button,
   output logic       team2_vu_button,
   output logic       team2_vd_button,
   output logic       team2_hl_button,
   output logic       team2_hr_button,
   output logic       code_valid,
   output logic [7:0] code,
   output logic       frame_error
);

   logic       break_q, break_d;
   logic       ext_q, ext_d;
   logic [7:0] held_q, held_d;
   key_hit_t   hit;

   ps2_frame_rx #(
      .FILTER_LEN     (FILTER_LEN),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_frame_rx (
      .clk         (clk),
      .rst         (rst),
      .ps2_clk     (ps2_clk),
      .ps2_data    (ps2_data),
      .code        (code),
      .code_valid  (code_valid),
      .frame_error (frame_error)
   );

   always_comb begin
      break_d = break_q;
      ext_d   = ext_q;
      held_d  = held_q;
      hit     = key_lookup(ext_q, code);
      if (frame_error) begin
         break_d = 1'b0;
         ext_d   = 1'b0;
      end else if (code_valid) begin
         if (code == SC_BREAK) begin
            break_d = 1'b1;
         end else if (code == SC_EXT) begin
            ext_d = 1'b1;
         end else begin
            // Typematic repeats rewrite the same value, so held keys stay put.
            if (hit.hit) begin
               held_d[hit.idx] = ~break_q;
            end
            break_d = 1'b0;
            ext_d   = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         break_q <= 1'b0;
         ext_q   <= 1'b0;
         held_q  <= 8'h00;
      end else begin
         break_q <= break_d;
         ext_q   <= ext_d;
         held_q  <= held_d;
      end
   end

   assign team1_vu_button = held_q[BTN_T1_VU] ? ACTIVE_LEVEL : ~ACTIVE_LEVEL;
   assign team1_vd_button = held_q[BTN_T1_VD] ? ACTIVE_LEVEL : ~ACTIVE_LEVEL;
   assign team1_hl_button = held_q[BTN_T1_HL] ? ACTIVE_LEVEL : ~ACTIVE_LEVEL;
   assign team1_hr_button = held_q[BTN_T1_HR] ? ACTIVE_LEVEL : ~ACTIVE_LEVEL;
   assign team2_vu_button = held_q[BTN_T2_VU] ? ACTIVE_LEVEL : ~ACTIVE_LEVEL;
   assign team2_vd_button = held_q[BTN_T2_VD] ? ACTIVE_LEVEL : ~ACTIVE_LEVEL;
   assign team2_hl_button = held_q[BTN_T2_HL] ? ACTIVE_LEVEL : ~ACTIVE_LEVEL;
   assign team2_hr_button = held_q[BTN_T2_HR] ? ACTIVE_LEVEL : ~ACTIVE_LEVEL;

endmodule

// File: tb/tb_ps2_button_receiver.sv
// Directed bench for ps2_button_receiver. The PS/2 bit rate and timeout are scaled down
// so the whole run stays short; button vector packs {team2 hr,hl,vd,vu, team1 hr,hl,vd,vu}.
module tb_ps2_button_receiver;

   localparam int unsigned FILTER_LEN = 8;
   localparam int unsigned TIMEOUT    = 2000;
   localparam int          HALF       = 20;  // clk cycles per PS/2 clock phase

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic       t1_vu, t1_vd, t1_hl, t1_hr, t2_vu, t2_vd, t2_hl, t2_hr;
   logic       code_valid, frame_error;
   logic [7:0] code;
   logic [7:0] btn;

   int n_checks = 0;
   int n_fail   = 0;
   int n_valid  = 0;
   int n_err    = 0;

   logic       got_valid, got_err;
   logic [7:0] btn_pre, btn_post;
   int         v0, e0;

   assign btn = {t2_hr, t2_hl, t2_vd, t2_vu, t1_hr, t1_hl, t1_vd, t1_vu};

   ps2_button_receiver #(
      .FILTER_LEN     (FILTER_LEN),
      .TIMEOUT_CYCLES (TIMEOUT),
      .ACTIVE_LEVEL   (1'b1)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .ps2_clk         (ps2_clk),
      .ps2_data        (ps2_data),
      .team1_vu_button (t1_vu),
      .team1_vd_button (t1_vd),
      .team1_hl_button (t1_hl),
      .team1_hr_button (t1_hr),
      .team2_vu_button (t2_vu),
      .team2_vd_button (t2_vd),
      .team2_hl_button (t2_hl),
      .team2_hr_button (t2_hr),
      .code_valid      (code_valid),
      .code            (code),
      .frame_error     (frame_error)
   );

   always #10 clk = ~clk;

   always @(negedge clk) begin
      if (!rst && code_valid)  n_valid++;
      if (!rst && frame_error) n_err++;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic ps2_bit(input logic b);
      @(negedge clk);
      ps2_data = b;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
   endtask

   // Sends a full frame; around the stop edge it captures the status pulse and the button
   // vector on the pulse cycle and on the following cycle.
   task automatic send_frame(input logic [7:0] b, input logic bad_par);
      logic seen, pending;
      logic [10:0] bits;
      bits = {1'b1, (~^b) ^ bad_par, b, 1'b0};
      got_valid = 1'b0;
      got_err   = 1'b0;
      btn_pre   = 8'hxx;
      btn_post  = 8'hxx;
      for (int i = 0; i < 10; i++) ps2_bit(bits[i]);
      @(negedge clk);
      ps2_data = 1'b1;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      seen    = 1'b0;
      pending = 1'b0;
      for (int i = 0; i < HALF; i++) begin
         @(negedge clk);
         if (pending) begin
            btn_post = btn;
            pending  = 1'b0;
         end else if (!seen && (code_valid || frame_error)) begin
            seen      = 1'b1;
            pending   = 1'b1;
            got_valid = code_valid;
            got_err   = frame_error;
            btn_pre   = btn;
         end
      end
      ps2_clk = 1'b1;
      repeat (3 * HALF) @(negedge clk);
   endtask

   task automatic expect_good(input string tag, input logic [7:0] c,
                              input logic [7:0] pre, input logic [7:0] post);
      check_eq({tag, " valid"}, {31'd0, got_valid}, 32'd1);
      check_eq({tag, " err"}, {31'd0, got_err}, 32'd0);
      check_eq({tag, " code"}, {24'd0, code}, {24'd0, c});
      check_eq({tag, " btn_pre"}, {24'd0, btn_pre}, {24'd0, pre});
      check_eq({tag, " btn_post"}, {24'd0, btn_post}, {24'd0, post});
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check_eq("reset btn", {24'd0, btn}, 32'h00);
      check_eq("reset code", {24'd0, code}, 32'h00);
      check_eq("reset valid", {31'd0, code_valid}, 32'd0);
      check_eq("reset err", {31'd0, frame_error}, 32'd0);
      rst = 1'b0;
      repeat (20) @(negedge clk);

      // Single make
      v0 = n_valid;
      send_frame(8'h1D, 1'b0);
      expect_good("make 1D", 8'h1D, 8'h00, 8'h01);
      check_eq("make 1D pulses", n_valid - v0, 32'd1);

      // Break
      v0 = n_valid;
      send_frame(8'hF0, 1'b0);
      expect_good("break F0", 8'hF0, 8'h01, 8'h01);
      send_frame(8'h1D, 1'b0);
      expect_good("break 1D", 8'h1D, 8'h01, 8'h00);
      check_eq("break pulses", n_valid - v0, 32'd2);

      // Extended make, keypad alias, typematic repeat, extended break
      send_frame(8'hE0, 1'b0);
      send_frame(8'h74, 1'b0);
      expect_good("E0 74", 8'h74, 8'h00, 8'h80);
      send_frame(8'h74, 1'b0);
      expect_good("keypad 74", 8'h74, 8'h80, 8'h80);
      send_frame(8'hE0, 1'b0);
      send_frame(8'h74, 1'b0);
      expect_good("repeat E0 74", 8'h74, 8'h80, 8'h80);
      send_frame(8'hE0, 1'b0);
      send_frame(8'hF0, 1'b0);
      send_frame(8'h74, 1'b0);
      expect_good("E0 F0 74", 8'h74, 8'h80, 8'h00);

      // Parity error, then good frame
      e0 = n_err;
      send_frame(8'h1C, 1'b1);
      check_eq("bad par err", {31'd0, got_err}, 32'd1);
      check_eq("bad par valid", {31'd0, got_valid}, 32'd0);
      check_eq("bad par code", {24'd0, code}, 32'h74);
      check_eq("bad par btn", {24'd0, btn}, 32'h00);
      check_eq("bad par pulses", n_err - e0, 32'd1);
      send_frame(8'h1C, 1'b0);
      expect_good("good 1C", 8'h1C, 8'h00, 8'h04);

      // Error clears the extended flag: 75 after it is keypad, unmapped
      send_frame(8'hE0, 1'b0);
      send_frame(8'h55, 1'b1);
      send_frame(8'h75, 1'b0);
      expect_good("err clears ext", 8'h75, 8'h04, 8'h04);

      // Unmapped bytes are ignored
      send_frame(8'hAA, 1'b0);
      expect_good("unmapped AA", 8'hAA, 8'h04, 8'h04);

      // Timeout: start + 4 data bits, then stall
      e0 = n_err;
      v0 = n_valid;
      ps2_bit(1'b0);
      for (int i = 0; i < 4; i++) ps2_bit(1'b1);
      @(negedge clk);
      ps2_data = 1'b1;
      repeat (TIMEOUT + 400) @(negedge clk);
      check_eq("timeout err pulses", n_err - e0, 32'd1);
      check_eq("timeout no valid", n_valid - v0, 32'd0);
      send_frame(8'h23, 1'b0);
      expect_good("after timeout 23", 8'h23, 8'h04, 8'h0C);

      // Glitches on ps2_clk with data low must not start a frame
      e0 = n_err;
      v0 = n_valid;
      ps2_data = 1'b0;
      for (int i = 0; i < 6; i++) begin
         ps2_clk = 1'b0;
         repeat (3) @(negedge clk);
         ps2_clk = 1'b1;
         repeat (12) @(negedge clk);
      end
      ps2_data = 1'b1;
      repeat (20) @(negedge clk);
      check_eq("glitch no valid", n_valid - v0, 32'd0);
      check_eq("glitch no err", n_err - e0, 32'd0);
      send_frame(8'h1D, 1'b0);
      expect_good("after glitch 1D", 8'h1D, 8'h0C, 8'h0D);
      send_frame(8'h1B, 1'b0);
      expect_good("hold 1B", 8'h1B, 8'h0D, 8'h0F);

      // Reset mid-frame
      ps2_bit(1'b0);
      ps2_bit(1'b1);
      ps2_bit(1'b0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_eq("midrst btn", {24'd0, btn}, 32'h00);
      check_eq("midrst code", {24'd0, code}, 32'h00);
      rst = 1'b0;
      ps2_data = 1'b1;
      repeat (50) @(negedge clk);
      send_frame(8'h1B, 1'b0);
      expect_good("after rst 1B", 8'h1B, 8'h00, 8'h02);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Hard stop if the stimulus ever stalls.
   initial begin
      #4000000;
      $display("FAIL watchdog: got timeout expected end of stimulus");
      $fatal(1);
   end

endmodule
